// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and next-PC select codes for pc_fetch_ctrl.
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {BOOT, RUN, IWAIT, ERR} state_t;
  localparam logic [1:0] PCSRC_INC    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a Decode source that needs the result of a load still in Execute.
module load_use_detect (
  input  logic       mem_read_E,
  input  logic [4:0] rd_E,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  output logic       lu
);
  assign lu = mem_read_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: next-PC select, PC/F-D enables and F-D/D-E flushes for the front end.
// Define PC_FETCH_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pc_fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_ready,
  input  logic                 branch_taken_E,
  input  logic                 jump_D,
  input  logic                 mem_read_E,
  input  logic [4:0]           rd_E,
  input  logic [4:0]           rs1_D,
  input  logic [4:0]           rs2_D,
  output logic [1:0]           PCsrc,
  output logic                 pc_en,
  output logic                 fd_en,
  output logic                 fd_flush,
  output logic                 de_flush,
  output logic                 fetch_err,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  state_t      state, state_nx;
  logic [3:0]  boot_cnt;
  logic [15:0] wait_cnt;
  logic        lu, active;
  load_use_detect u_lu (
    .mem_read_E(mem_read_E),
    .rd_E(rd_E),
    .rs1_D(rs1_D),
    .rs2_D(rs2_D),
    .lu(lu)
  );
  assign active    = (state == RUN) || (state == IWAIT);
  assign fetch_err = (state == ERR);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= BOOT;
      boot_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      boot_cnt <= (state == BOOT) ? boot_cnt + 4'd1 : '0;
      wait_cnt <= (!active || imem_ready) ? '0 : wait_cnt + 16'd1;
    end
  always_comb begin
    state_nx = state;
    if (state == BOOT)
      state_nx = (boot_cnt == BOOT_LAST) ? RUN : BOOT;
    else if (state != ERR)
      state_nx = imem_ready ? RUN : (wait_cnt == WAIT_LAST) ? ERR : IWAIT;
  end
  // BOOT and ERR share the default: everything held, both registers bubbled.
  always_comb begin
    PCsrc    = PCSRC_INC;
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    fd_flush = 1'b1;
    de_flush = 1'b1;
    if (active) begin
      if (branch_taken_E) begin
        PCsrc = PCSRC_BRANCH;
        pc_en = 1'b1;
        fd_en = 1'b1;
      end else if (!imem_ready || lu) begin
        fd_flush = 1'b0;
      end else if (jump_D) begin
        PCsrc    = PCSRC_JUMP;
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_flush = 1'b0;
      end else begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
      end
    end
  end
`ifdef PC_FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (active && !pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (active && fd_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and randomized checks of pc_fetch_ctrl against a cycle-level reference model.
module tb_pc_fetch_ctrl;
  localparam int BOOTC = 2;
  localparam int TO    = 4;
  localparam logic [6:0] V_BOOT   = 7'b00_0_0_1_1_0;
  localparam logic [6:0] V_ERR    = 7'b00_0_0_1_1_1;
  localparam logic [6:0] V_BRANCH = 7'b01_1_1_1_1_0;
  localparam logic [6:0] V_STALL  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] V_JUMP   = 7'b10_1_1_1_0_0;
  localparam logic [6:0] V_NORM   = 7'b00_1_1_0_0_0;
  logic clk = 1'b0, rst = 1'b0;
  logic imem_ready, branch_taken_E, jump_D, mem_read_E;
  logic [4:0] rd_E, rs1_D, rs2_D;
  logic [1:0] PCsrc;
  logic pc_en, fd_en, fd_flush, de_flush, fetch_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0] obs;
  int checks = 0, failures = 0;
  int boot_left, waits;
  bit err_m;
  longint stall_m, flush_m;
  always #5 clk = ~clk;
  pc_fetch_ctrl #(.BOOT_CYCLES(BOOTC), .TIMEOUT(TO), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .branch_taken_E(branch_taken_E),
    .jump_D(jump_D), .mem_read_E(mem_read_E), .rd_E(rd_E), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .PCsrc(PCsrc), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .fetch_err(fetch_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  assign obs = {PCsrc, pc_en, fd_en, fd_flush, de_flush, fetch_err};
  function automatic logic [6:0] model_out();
    bit hz = mem_read_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    if (boot_left > 0) return V_BOOT;
    if (err_m) return V_ERR;
    if (branch_taken_E) return V_BRANCH;
    if (!imem_ready || hz) return V_STALL;
    if (jump_D) return V_JUMP;
    return V_NORM;
  endfunction
  task automatic set_in(bit br, bit j, bit rdy, bit mr, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
    branch_taken_E = br; jump_D = j; imem_ready = rdy; mem_read_E = mr;
    rd_E = rd; rs1_D = r1; rs2_D = r2;
  endtask
  task automatic idle();
    set_in(0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic model_reset();
    boot_left = BOOTC; err_m = 0; waits = 0; stall_m = 0; flush_m = 0;
  endtask
  task automatic tick();
    logic [6:0] cur = model_out();
    @(posedge clk);
    if (boot_left > 0) boot_left--;
    else if (!err_m) begin
      if (!cur[5]) stall_m++;
      if (cur[3]) flush_m++;
      if (!imem_ready) begin
        waits++;
        if (waits == TO) err_m = 1;
      end else waits = 0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask
  task automatic boot_through();
    do_reset();
    repeat (BOOTC) tick();
  endtask
  task automatic test_reset();
    idle();
    model_reset();
    #1;
    checks++;
    if (obs !== V_BOOT || stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++; $display("FAIL reset_vals got=%b exp=%b cnt=%0d/%0d", obs, V_BOOT, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < BOOTC; i++) begin
      #1; checks++;
      if (obs !== V_BOOT) begin failures++; $display("FAIL boot_hold%0d got=%b exp=%b", i, obs, V_BOOT); end
      tick();
    end
    #1; checks++;
    if (obs !== V_NORM) begin failures++; $display("FAIL boot_exit got=%b exp=%b", obs, V_NORM); end
    repeat (3) tick();
    #3 rst = 1'b0;
    #1; checks++;
    if (obs !== V_BOOT) begin failures++; $display("FAIL async_reset got=%b exp=%b", obs, V_BOOT); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1; checks++;
    if (obs !== V_BOOT) begin failures++; $display("FAIL reboot got=%b exp=%b", obs, V_BOOT); end
    repeat (BOOTC) tick();
  endtask
  task automatic test_load_use();
    set_in(0, 0, 1, 1, 5, 0, 5);
    #1; checks++;
    if (obs !== V_STALL) begin failures++; $display("FAIL lu_stall got=%b exp=%b", obs, V_STALL); end
    tick();
    idle();
    #1; checks++;
    if (obs !== V_NORM) begin failures++; $display("FAIL lu_one_bubble got=%b exp=%b", obs, V_NORM); end
    tick();
    set_in(0, 0, 1, 1, 0, 0, 0);
    #1; checks++;
    if (obs !== V_NORM) begin failures++; $display("FAIL lu_rd0 got=%b exp=%b", obs, V_NORM); end
    tick();
  endtask
  task automatic test_branch_priority();
    set_in(1, 1, 0, 1, 3, 3, 3);
    #1; checks++;
    if (obs !== V_BRANCH) begin failures++; $display("FAIL branch_prio got=%b exp=%b", obs, V_BRANCH); end
    tick();
    idle();
    #1; checks++;
    if (obs !== V_NORM) begin failures++; $display("FAIL branch_after got=%b exp=%b", obs, V_NORM); end
    tick();
  endtask
  task automatic test_jump_lu();
    set_in(0, 1, 1, 1, 7, 7, 2);
    #1; checks++;
    if (obs !== V_STALL) begin failures++; $display("FAIL jump_lu_stall got=%b exp=%b", obs, V_STALL); end
    tick();
    set_in(0, 1, 1, 0, 0, 7, 2);
    #1; checks++;
    if (obs !== V_JUMP) begin failures++; $display("FAIL jump_replay got=%b exp=%b", obs, V_JUMP); end
    tick();
    idle();
  endtask
  task automatic test_timeout();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      #1; checks++;
      if (obs !== V_STALL) begin failures++; $display("FAIL wait%0d got=%b exp=%b", i, obs, V_STALL); end
      tick();
    end
    idle();
    #1; checks++;
    if (obs !== V_NORM) begin failures++; $display("FAIL wait_recover got=%b exp=%b", obs, V_NORM); end
    tick();
    #1; checks++;
    if (obs !== V_NORM) begin failures++; $display("FAIL back_to_run got=%b exp=%b", obs, V_NORM); end
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (TO) tick();
    #1; checks++;
    if (obs !== V_ERR) begin failures++; $display("FAIL timeout_err got=%b exp=%b", obs, V_ERR); end
    set_in(1, 1, 1, 0, 0, 0, 0);
    repeat (2) tick();
    #1; checks++;
    if (obs !== V_ERR) begin failures++; $display("FAIL err_sticky got=%b exp=%b", obs, V_ERR); end
    idle();
    do_reset();
    checks++;
    if (fetch_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", fetch_err); end
    repeat (BOOTC) tick();
  endtask
  task automatic test_perf();
    logic [31:0] es, ef;
`ifdef PC_FETCH_CTRL_PERF_EN
    es = 3; ef = 1;
`else
    es = 0; ef = 0;
`endif
    boot_through();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 1, 9, 9, 1);
      tick();
      idle();
      tick();
    end
    set_in(1, 0, 1, 0, 0, 0, 0);
    tick();
    idle();
    #1; checks++;
    if (stall_cnt !== es || flush_cnt !== ef) begin
      failures++; $display("FAIL perf_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, es, ef);
    end
  endtask
  task automatic test_random();
    logic [6:0] e;
    int bad = 0;
    boot_through();
    for (int n = 0; n < 800; n++) begin
      if (n % 200 == 199) boot_through();
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)));
      #1;
      e = model_out();
      checks++;
      if (obs !== e) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_out n=%0d got=%b exp=%b", n, obs, e);
      end
      tick();
    end
    idle();
    #1; checks++;
`ifdef PC_FETCH_CTRL_PERF_EN
    if (stall_cnt !== 32'(stall_m) || flush_cnt !== 32'(flush_m)) begin
      failures++; $display("FAIL rand_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, stall_m, flush_m);
    end
`else
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++; $display("FAIL rand_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_jump_lu();
    test_timeout();
    test_perf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
